// File: rtl/hex_scroller.sv
// ---------------------------------------------------------------------------
// hex_scroller
//   Scrolls a small character buffer across a row of active-low seven-segment
//   digits. A free-running prescaler produces a scroll tick every
//   2^PRESCALE_W clocks; a three-state FSM (STATIC / SCROLL / HOLD) decides
//   whether the tick moves the window offset.
//
// Ports
//   CLOCK_27  single clock, all state updates on the rising edge
//   KEY0      synchronous active-low reset
//   en        prescaler run enable (0 freezes prescaler and offset)
//   mode      00 static, 01 continuous scroll, 10 single pass then hold,
//             11 same as 00
//   dir       0 scroll left (offset increments), 1 scroll right (decrements)
//   wr_en     message write strobe
//   wr_addr   message write address (addresses >= MSG_LEN are ignored)
//   wr_char   5-bit character code (0-15 hex glyphs, 16-31 blank)
//   HEX       active-low segments, digit i at [7i+6:7i], bit 0 = a .. 6 = g
//   wrap      one-cycle pulse the cycle after the offset wraps
//   busy      high while the FSM is in SCROLL
// ---------------------------------------------------------------------------
module hex_scroller #(
    parameter int NUM_DIGITS = 8,
    parameter int MSG_LEN    = 16,
    parameter int PRESCALE_W = 23
) (
    input  logic                         CLOCK_27,
    input  logic                         KEY0,
    input  logic                         en,
    input  logic [1:0]                   mode,
    input  logic                         dir,
    input  logic                         wr_en,
    input  logic [$clog2(MSG_LEN)-1:0]   wr_addr,
    input  logic [4:0]                   wr_char,
    output logic [7*NUM_DIGITS-1:0]      HEX,
    output logic                         wrap,
    output logic                         busy
);

    localparam int             AW         = $clog2(MSG_LEN);
    localparam logic [AW-1:0]  LAST       = AW'(MSG_LEN - 1);
    localparam logic [4:0]     BLANK_CODE = 5'd16;

    typedef enum logic [1:0] {
        ST_STATIC,
        ST_SCROLL,
        ST_HOLD
    } state_t;

    state_t                  state, state_nxt;
    logic [PRESCALE_W-1:0]   presc;
    logic                    tick;
    logic [AW-1:0]           offset, offset_nxt;
    logic                    wrap_cond;
    logic                    wrap_nxt;
    logic [4:0]              msg [MSG_LEN];
    logic [7*NUM_DIGITS-1:0] hex_nxt;
    logic                    addr_ok;

    // Active-low glyphs, segment order gfedcba.
    function automatic logic [6:0] seg_decode(input logic [4:0] code);
        case (code)
            5'd0:    seg_decode = 7'h40;
            5'd1:    seg_decode = 7'h79;
            5'd2:    seg_decode = 7'h24;
            5'd3:    seg_decode = 7'h30;
            5'd4:    seg_decode = 7'h19;
            5'd5:    seg_decode = 7'h12;
            5'd6:    seg_decode = 7'h02;
            5'd7:    seg_decode = 7'h78;
            5'd8:    seg_decode = 7'h00;
            5'd9:    seg_decode = 7'h10;
            5'd10:   seg_decode = 7'h08;
            5'd11:   seg_decode = 7'h03;
            5'd12:   seg_decode = 7'h46;
            5'd13:   seg_decode = 7'h21;
            5'd14:   seg_decode = 7'h06;
            5'd15:   seg_decode = 7'h0E;
            default: seg_decode = 7'h7F;
        endcase
    endfunction

    assign tick = en && (presc == '1);
    assign busy = (state == ST_SCROLL);

    // The tick that moves the offset across the MSG_LEN-1 / 0 seam.
    assign wrap_cond = dir ? (offset == '0) : (offset == LAST);

    // Widened compare so the range test stays meaningful when MSG_LEN is a
    // power of two.
    assign addr_ok = ({1'b0, wr_addr} < (AW + 1)'(MSG_LEN));

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path leaves it unassigned, which would infer a latch.
        state_nxt  = state;
        offset_nxt = offset;
        wrap_nxt   = 1'b0;

        case (state)
            ST_STATIC: begin
                if (mode == 2'b01 || mode == 2'b10) state_nxt = ST_SCROLL;
            end
            ST_SCROLL: begin
                if (tick) begin
                    if (dir) offset_nxt = (offset == '0)  ? LAST : offset - 1'b1;
                    else     offset_nxt = (offset == LAST) ? '0  : offset + 1'b1;
                    wrap_nxt = wrap_cond;
                end
                if (mode == 2'b00 || mode == 2'b11)
                    state_nxt = ST_STATIC;
                else if (mode == 2'b10 && tick && wrap_cond)
                    state_nxt = ST_HOLD;
            end
            ST_HOLD: begin
                // Offset sits where the final wrap left it (0 or MSG_LEN-1).
                if (mode == 2'b01)      state_nxt = ST_SCROLL;
                else if (mode != 2'b10) state_nxt = ST_STATIC;
            end
            default: state_nxt = ST_STATIC;
        endcase
    end

    // Digit i looks at msg[(offset + i) mod MSG_LEN]; the modulo also covers
    // NUM_DIGITS > MSG_LEN, where characters simply repeat.
    always_comb begin
        hex_nxt = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            hex_nxt[7*i +: 7] = seg_decode(msg[AW'((int'(offset) + i) % MSG_LEN)]);
        end
    end

    always_ff @(posedge CLOCK_27) begin
        if (!KEY0) begin
            presc  <= '0;
            offset <= '0;
            state  <= ST_STATIC;
            wrap   <= 1'b0;
            HEX    <= '1;
            // NOTE: the buffer is built from flops rather than RAM precisely
            // so that reset can clear every entry to blank in one edge.
            for (int i = 0; i < MSG_LEN; i++) msg[i] <= BLANK_CODE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values of the others.
            if (en) presc <= presc + 1'b1;
            offset <= offset_nxt;
            state  <= state_nxt;
            wrap   <= wrap_nxt;
            HEX    <= hex_nxt;
            if (wr_en && addr_ok) msg[wr_addr] <= wr_char;
        end
    end

endmodule
